// File: rtl/cla_pipe_pkg.sv
// Shared definitions for the segmented carry-lookahead pipeline.
// CLA_PIPE_FLAGS_EN adds the zero accumulator to the per-stage record.
package cla_pipe_pkg;

  function automatic int seg_width(input int w, input int s);
    return (s > 0) ? (w / s) : w;
  endfunction

  // Control half of a stage record; the skewed operands and deskewed result
  // live beside it in each stage because their widths differ per stage.
  typedef struct packed {
    logic vld;
    logic carry;
`ifdef CLA_PIPE_FLAGS_EN
    logic zacc;
`endif
  } stage_ctl_t;

endpackage

// File: rtl/cla_pipe_cla.sv
// Combinational segment adder built from generate/propagate terms.
// SW is small, so a flat g/p carry chain fits within one pipeline stage.
module cla_pipe_cla #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign c[i+1] = g[i] | (p[i] & c[i]);
  end

  assign sum  = p ^ c[W-1:0];
  assign cout = c[W];

endmodule

// File: rtl/cla_pipe.sv
// Pipelined add/subtract: stage k adds segment k and registers the carry into k+1.
// CLA_PIPE_FLAGS_EN adds o_ovf / o_zero, aligned with o_y.
module cla_pipe
  import cla_pipe_pkg::*;
#(
  parameter int W = 32,
  parameter int S = 4
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         i_vld,
  output logic         o_rdy,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  input  logic         i_sub,
  output logic         o_vld,
  input  logic         i_rdy,
  output logic [W-1:0] o_y,
  output logic         o_cout
`ifdef CLA_PIPE_FLAGS_EN
  ,
  output logic         o_ovf,
  output logic         o_zero
`endif
);

  localparam int SW = seg_width(W, S);

  if (S < 1 || (W % S) != 0) begin : g_bad_split
    $error("cla_pipe: W=%0d does not split into S=%0d equal segments", W, S);
  end

  logic adv;
  assign adv   = ~o_vld | i_rdy;
  assign o_rdy = adv;

  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam int LO = k * SW;

    // Operand bits still to be consumed: segment k in the low SW bits.
    logic [W-LO-1:0]    a_src;
    logic [W-LO-1:0]    b_src;
    logic [LO+SW-1:0]   y_nxt;
    logic [LO+SW-1:0]   y_q;
    logic [SW-1:0]      sum;
    logic               cout;
    stage_ctl_t         ctl_src;
    stage_ctl_t         ctl_nxt;
    stage_ctl_t         ctl_q;

    if (k == 0) begin : g_head
      assign a_src = i_a;
      assign b_src = i_b ^ {W{i_sub}};
      assign y_nxt = sum;
      always_comb begin
        ctl_src       = '0;
        ctl_src.vld   = i_vld;
        ctl_src.carry = i_cin;
`ifdef CLA_PIPE_FLAGS_EN
        ctl_src.zacc  = 1'b1;
`endif
      end
    end else begin : g_body
      assign a_src   = g_stage[k-1].g_skew.a_q;
      assign b_src   = g_stage[k-1].g_skew.b_q;
      assign y_nxt   = {sum, g_stage[k-1].y_q};
      assign ctl_src = g_stage[k-1].ctl_q;
    end

    cla_pipe_cla #(.W(SW)) u_cla (
      .a    (a_src[SW-1:0]),
      .b    (b_src[SW-1:0]),
      .cin  (ctl_src.carry),
      .sum  (sum),
      .cout (cout)
    );

    always_comb begin
      ctl_nxt       = ctl_src;
      ctl_nxt.carry = cout;
`ifdef CLA_PIPE_FLAGS_EN
      ctl_nxt.zacc  = ctl_src.zacc & ~|sum;
`endif
    end

    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        ctl_q <= '0;
        y_q   <= '0;
      end else if (adv) begin
        ctl_q <= ctl_nxt;
        y_q   <= y_nxt;
      end
    end

    if (k < S - 1) begin : g_skew
      logic [W-LO-SW-1:0] a_q;
      logic [W-LO-SW-1:0] b_q;

      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_src[W-LO-1:SW];
          b_q <= b_src[W-LO-1:SW];
        end
      end
    end
  end

  assign o_vld  = g_stage[S-1].ctl_q.vld;
  assign o_y    = g_stage[S-1].y_q;
  assign o_cout = g_stage[S-1].ctl_q.carry;

`ifdef CLA_PIPE_FLAGS_EN
  logic ovf_nxt;
  logic ovf_q;

  // Carry into bit W-1 recovered from the top sum bit and its operands.
  assign ovf_nxt = g_stage[S-1].sum[SW-1] ^ g_stage[S-1].a_src[SW-1]
                 ^ g_stage[S-1].b_src[SW-1] ^ g_stage[S-1].cout;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_nxt;
    end
  end

  assign o_ovf  = ovf_q;
  assign o_zero = g_stage[S-1].ctl_q.zacc;
`endif

endmodule

// File: doc/cla_pipe.md
Name: cla_pipe

Overview:
- Pipelined, parametrised carry-lookahead add/subtract unit for the datapath, with valid/ready handshakes on both sides.
- Splits a W-bit operation into S segments of W/S bits. Each pipeline stage resolves one segment and registers the inter-segment carry.
- Sustains one operation per cycle at clock rates a single-cycle W-bit adder cannot meet.
- Used by the ALU and address-generation paths where W ≥ 32.

Parameters:
W, 32, operand/result width in bits
S, 4, number of segments = pipeline stages; W % S == 0 required (elaboration-time assertion); SW = W/S

Ports:
clk  input  1  clock
arst_n  input  1  asynchronous active-low reset
i_vld  input  1  input operation valid
o_rdy  output  1  unit accepts input this cycle
i_a  input  W  operand A
i_b  input  W  operand B
i_cin  input  1  carry-in
i_sub  input  1  1: B is inverted before addition
o_vld  output  1  result valid
i_rdy  input  1  downstream accepts result
o_y  output  W  result
o_cout  output  1  carry-out of bit W-1

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is asynchronous and active-low on arst_n; all state is cleared on assertion.
  - On reset, all stage valid bits are 0, all data/carry registers are 0, so o_vld=0, o_y=0 and o_cout=0.
- Arithmetic:
  - i_sub=0: {o_cout,o_y} = i_a + i_b + i_cin.
  - i_sub=1: {o_cout,o_y} = i_a + ~i_b + i_cin. True A−B requires i_cin=1; the caller drives it.
  - Results wrap modulo 2^W.
- Stage k (0..S-1):
  - Adds segment k of A and B' (B' = B ^ {W{i_sub}}) with carry c_k.
  - c_0 = i_cin; c_{k+1} is the registered carry-out of stage k.
- Skewing:
  - Input segments of higher significance are carried forward in skew registers until their stage.
  - Completed lower result segments are carried forward in deskew registers.
  - Result appears whole at the final stage.
- Latency and throughput:
  - Accept to o_vld is exactly S cycles with no stall.
  - Throughput is one operation per cycle.
  - S=1 degenerates to a single registered adder, latency 1.
- Handshake:
  - Transfer in occurs when i_vld & o_rdy; transfer out occurs when o_vld & i_rdy.
  - adv = ~o_vld | i_rdy. o_rdy = adv, so o_rdy is combinational from i_rdy and o_vld.
  - When adv=1, every stage register (valid, data, carry, skew) shifts one stage. Stage 0 loads the input, with valid = i_vld.
  - When adv=0, all pipeline registers hold.
  - Bubbles are not compressed.
- o_y and o_cout are stable while o_vld=1 and i_rdy=0.
- Boundary conditions:
  - Simultaneous accept and emit with a full pipe (S operations in flight, i_rdy=1) proceeds at full rate without loss.
  - i_vld=0 with adv=1 inserts a bubble.
  - Carry propagates across all segments, e.g. 0xFFFF_FFFF + 1.
  - Mid-operation reset discards all in-flight operations; o_vld falls asynchronously.
- Inputs are sampled only on accepted cycles.
- Inputs when i_vld=0 are don't-care, and their data must not propagate to o_vld=1 outputs.

Optional Feature:
- Macro: CLA_PIPE_FLAGS_EN.
- When defined, adds two outputs:
  - o_ovf (1, output): signed overflow = carry into bit W-1 XOR o_cout.
  - o_zero (1, output): o_y == 0.
- Flag timing:
  - Both flags are valid with o_vld and held under stall, with the same latency.
  - The zero flag is accumulated per stage as an AND of segment-zero bits, carried in the pipe.
  - Both flags reset to 0.
- When undefined, these ports and their logic are absent. Area and ports are identical to the base configuration.

Decomposition:
- Package cla_pipe_pkg holds:
  - Localparam helper function for SW.
  - Typedef of a stage record: {vld, carry, skewed operand bits, deskewed result bits, zero acc}.
- Sub-module: the existing cla adder, instantiated S times at W=SW as the combinational segment adder.

Test Plan:
- W=32,S=4, i_rdy=1: A=0x0000_0001,B=0x0000_0002,cin=0,sub=0 at cycle 0 -> o_vld at cycle 4, o_y=0x0000_0003, o_cout=0.
- A=0xFFFF_FFFF,B=0x0000_0001,cin=0 -> o_y=0x0000_0000, o_cout=1 (full cross-segment ripple); with CLA_PIPE_FLAGS_EN o_zero=1, o_ovf=0.
- sub=1,cin=1,A=5,B=7 -> o_y=0xFFFF_FFFE, o_cout=0; A=0x8000_0000,B=1 -> o_y=0x7FFF_FFFF, o_ovf=1.
- Back-to-back stream of 100 random ops, i_rdy=1 -> one result per cycle, in order, matches reference model.
- Fill pipe then hold i_rdy=0 for 10 cycles -> o_rdy=0, o_y/o_cout stable, no loss/duplication after i_rdy returns.
- Assert arst_n low with 3 ops in flight -> o_vld=0 immediately; after release, first new op emerges exactly S cycles after accept.
